event_log_arbiter: RTL
======================

# event_log_arbiter

Shares the time-of-day value `horario` from the clock counter among several event sources (keypad unlock, wrong-code alarm, door sensor, admin) and logs each event as a timestamped entry in a circular buffer. The block detects a rising edge on each requester line, latches `horario` for that requester at that moment, and grants the log write port round-robin, one source per cycle. It sits between the clock counter, the lock FSMs and the display/readout logic, which drains entries through a show-ahead read port.

## Interface
- `N_REQ`, 4: number of requesters (2..4); source ID width fixed at 2 bits.
- `DEPTH`, 8: log entries, power of two ≥ 2.
- `clk_1Hz`  in  1  design clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `horario`  in  17  current time in seconds, 0..86399.
- `req`  in  N_REQ  event request lines; a rising edge is one event.
- `grant`  out  N_REQ  one-hot, registered; high for the one cycle after the entry of that source is written.
- `rd_en`  in  1  pop the head entry.
- `rd_data`  out  19  head entry `{src_id[1:0], timestamp[16:0]}`; 0 when empty.
- `empty`  out  1  log holds 0 entries.
- `full`  out  1  log holds DEPTH entries.
- `count`  out  clog2(DEPTH)+1  entries held, 0..DEPTH.
- `overflow`  out  1  sticky; an event was lost.

## Operation
- Edge detect: `req_q` registers `req`; event on source i at edge k when `req[i]=1` and `req_q[i]=0`.
- On event: `pend[i]←1`, `ts[i]←horario` sampled at edge k.
- Event on i while `pend[i]=1` and i is not being written at that edge: `pend`/`ts` keep the old event; `overflow←1`.
- Event on i at the same edge where i is written: `pend[i]` stays set with the new `ts[i]`; no overflow.
- Arbiter: combinational round-robin over `pend`, searching from `last+1` with wrap-around; `last` resets to N_REQ-1, so source 0 has first priority after reset.
- Write happens when any `pend` bit is set and (`!full` or `rd_en`): `mem[wr_ptr]←{i, ts[i]}`, `wr_ptr++` (mod DEPTH), `pend[i]←0`, `last←i`, `grant←onehot(i)`. Otherwise `grant←0`.
- Read: `rd_en` with `!empty` pops: `rd_ptr++`. `rd_en` while empty is ignored.
- Simultaneous write and read: both happen; `count` unchanged.
- Reset, including during operation: `pend`, `req_q`, `ts`, pointers, `last`, `grant`, `overflow` and count clear. Memory is not cleared and is unobservable.

## Timing
- Reset values: `grant=0`, `rd_data=0`, `empty=1`, `full=0`, `count=0`, `overflow=0`.
- Latency: an edge of `req` sampled at edge k gives a write at edge k+1 at the earliest, with `grant` high during cycle k+1..k+2. Each cycle of arbitration loss adds one cycle.
- Throughput: one write per cycle. With 4 sources pulsing together, writes occur at edges k+1..k+4.
- `rd_data`, `empty`, `full` and `count` reflect state after the last edge. Show-ahead: `rd_data` is valid combinationally while `!empty`.
- `count` updates: +1 on write only, −1 on pop only.

## Configuration
- `EVLOG_OVERWRITE_EN` defined: a write with `full` and no `rd_en` is still performed. It overwrites the oldest entry, `rd_ptr++`, `count` stays DEPTH, and `overflow←1`. Pending events never stall.
- Not defined: with `full` and no `rd_en` there is no write. Sources stay pending and `grant=0` until space frees; loss only occurs through the re-event rule.

## Test plan
- Reset, then `horario=100`, pulse `req[2]` for 1 cycle → next cycle `grant=4'b0100`; after that edge `rd_data={2'd2,17'd100}`, `count=1`; `rd_en` for 1 cycle → `empty=1`, `rd_data=0`.
- Pulse `req=4'b1111` with `horario=500` → grants 0,1,2,3 on consecutive cycles; popped entries are src 0..3, all with timestamp 500. Then pulse `req=4'b1001` → order 0,3 (pointer after 3 wraps to 0).
- Hold `req[1]` high for 5 cycles → exactly one entry is logged.
- Without the macro, fill 8 entries (`full=1`), then pulse `req[0]` at `horario=900` → no grant. Pulse `req[0]` again → `overflow=1`. One `rd_en` → entry `{0,900}` written the same edge, `count=8`.
- With `EVLOG_OVERWRITE_EN`, fill to 8 and then log a 9th event → `count=8`, head is the former 2nd entry, `overflow=1`.
- Assert `reset` while events are pending and `count=3` → next cycle all outputs are at reset values, and no stale grant or entry appears afterwards.

Source files
------------

// File: rtl/event_log_arbiter.sv
// -----------------------------------------------------------------------------
// event_log_arbiter
//
// Timestamped event logger shared by several event sources. A rising edge on
// any requester line latches the current time of day (horario) for that
// source. A round-robin arbiter then writes one pending event per cycle into
// a circular log. The log is drained through a show-ahead read port.
//
// Ports
//   clk_1Hz   in   design clock, rising edge
//   reset     in   synchronous, active-high reset
//   horario   in   current time in seconds (0..86399)
//   req       in   N_REQ event request lines; a rising edge is one event
//   grant     out  one-hot, registered; high the cycle after that source's
//                  entry is written
//   rd_en     in   pop the head entry
//   rd_data   out  head entry {src_id[1:0], timestamp[16:0]}; 0 when empty
//   empty     out  log holds no entries
//   full      out  log holds DEPTH entries
//   count     out  number of entries held (0..DEPTH)
//   overflow  out  sticky flag: an event was lost
//
// Build option
//   EVLOG_OVERWRITE_EN : when defined, a write into a full log with no pop
//                        overwrites the oldest entry and sets overflow, so
//                        pending events never stall. When undefined, sources
//                        stay pending until space frees.
// -----------------------------------------------------------------------------
module event_log_arbiter #(
   parameter int N_REQ = 4,
   parameter int DEPTH = 8
) (
   input  logic                     clk_1Hz,
   input  logic                     reset,
   input  logic [16:0]              horario,
   input  logic [N_REQ-1:0]         req,
   output logic [N_REQ-1:0]         grant,
   input  logic                     rd_en,
   output logic [18:0]              rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int          AW = $clog2(DEPTH);
   localparam int unsigned NR = N_REQ;

   // registered state
   logic [N_REQ-1:0] req_q;
   logic [N_REQ-1:0] pend_q, pend_d;
   logic [16:0]      ts_q [N_REQ];
   logic [16:0]      ts_d [N_REQ];
   logic [1:0]       last_q, last_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             overflow_q, overflow_d;

   logic [18:0]      mem [DEPTH];

   // combinational helpers
   logic [N_REQ-1:0] event_v;
   logic             any_pend;
   logic             found;
   logic [1:0]       sel;
   logic [16:0]      sel_ts;
   logic             wr_en;
   logic             adv_rd;
   logic             pop;
   logic             ovw_loss;

   assign empty    = (count_q == '0);
   assign full     = (count_q == (AW+1)'(DEPTH));
   assign count    = count_q;
   assign grant    = grant_q;
   assign overflow = overflow_q;
   assign rd_data  = empty ? '0 : mem[rd_ptr_q];

   assign event_v  = req & ~req_q;
   assign any_pend = |pend_q;
   assign pop      = rd_en && !empty;

   // Round-robin: search from last+1 with wrap; first pending source wins.
   always_comb begin
      int unsigned idx;
      found  = 1'b0;
      sel    = '0;
      sel_ts = '0;
      for (int unsigned k = 1; k <= NR; k++) begin
         idx = (32'(last_q) + k) % NR;
         if (!found && pend_q[idx]) begin
            found  = 1'b1;
            sel    = idx[1:0];
            sel_ts = ts_q[idx];
         end
      end
   end

`ifdef EVLOG_OVERWRITE_EN
   // A full log with no pop drops its oldest entry to make room.
   assign wr_en    = any_pend;
   assign ovw_loss = wr_en && full && !rd_en;
   assign adv_rd   = pop || ovw_loss;
`else
   assign wr_en    = any_pend && (!full || rd_en);
   assign ovw_loss = 1'b0;
   assign adv_rd   = pop;
`endif

   always_comb begin
      pend_d     = pend_q;
      overflow_d = overflow_q || ovw_loss;
      for (int unsigned i = 0; i < NR; i++) begin
         ts_d[i]    = ts_q[i];
         grant_d[i] = wr_en && (sel == i[1:0]);
         // An event on a source being written this edge replaces the entry
         // leaving; otherwise a re-event while pending is lost.
         if (event_v[i]) begin
            if (pend_q[i] && !grant_d[i]) begin
               overflow_d = 1'b1;
            end else begin
               pend_d[i] = 1'b1;
               ts_d[i]   = horario;
            end
         end else if (grant_d[i]) begin
            pend_d[i] = 1'b0;
         end
      end

      last_d   = wr_en  ? sel : last_q;
      wr_ptr_d = wr_en  ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = adv_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

      count_d = count_q;
      if (wr_en && !adv_rd)      count_d = count_q + 1'b1;
      else if (adv_rd && !wr_en) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_1Hz) begin
      if (reset) begin
         req_q      <= '0;
         pend_q     <= '0;
         last_q     <= 2'(N_REQ - 1);
         grant_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         for (int unsigned i = 0; i < NR; i++) ts_q[i] <= '0;
      end else begin
         req_q      <= req;
         pend_q     <= pend_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         for (int unsigned i = 0; i < NR; i++) ts_q[i] <= ts_d[i];
      end
   end

   // Log storage is not reset; stale contents are hidden by the pointers.
   always_ff @(posedge clk_1Hz) begin
      if (!reset && wr_en) mem[wr_ptr_q] <= {sel, sel_ts};
   end

endmodule
